// File: rtl/atm_keypad_entry.sv
// atm_keypad_entry: keypad front end for the ATM controller.
// Collects decimal key presses into a BCD shift buffer, converts them to a
// 16-bit binary value one digit per cycle, and presents the result (or an
// error code) with a valid/ack handshake.
`timescale 1ns/1ps
module atm_keypad_entry #(
   parameter int PIN_DIGITS     = 4,
   parameter int MAX_DIGITS     = 5,
   parameter int MAX_AMOUNT     = 10000,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        card_inserted,
   input  logic        mode,
   input  logic        start,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   input  logic        value_ack,
   output logic [15:0] value,
   output logic        value_valid,
   output logic        error_valid,
   output logic [1:0]  entry_error,
   output logic [2:0]  digit_count,
   output logic        busy
);

   localparam int             BW        = 4 * MAX_DIGITS;
   localparam int             TW        = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0]  TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]     PIN_LIM   = 3'(PIN_DIGITS);
   localparam logic [2:0]     MAX_LIM   = 3'(MAX_DIGITS);
   localparam logic [16:0]    AMT_LIM   = 17'(MAX_AMOUNT);

   localparam logic [3:0] K_CLEAR  = 4'd10;
   localparam logic [3:0] K_BACK   = 4'd11;
   localparam logic [3:0] K_ENTER  = 4'd12;
   localparam logic [3:0] K_CANCEL = 4'd13;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_CONVERT,
      S_HOLD,
      S_ERR
   } state_t;

   state_t          r_state;
   logic            r_busy;
   logic            r_mode;
   logic [BW-1:0]   r_bcd;
   logic [2:0]      r_count;
   logic [2:0]      r_idx;
   logic [16:0]     r_acc;
   logic [TW-1:0]   r_timer;
   logic [15:0]     r_value;
   logic            r_value_valid;
   logic            r_error_valid;
   logic [1:0]      r_entry_error;

   logic [3:0]      w_digit [0:7];
   logic [3:0]      w_cur_digit;
   logic [16:0]     w_acc_next;
   logic [2:0]      w_limit;
   logic            w_key_accepted;
   logic            w_is_digit;
   logic            w_enter_bad;

   // Expose each buffered BCD digit by position; unused slots read as zero
   // so the 3-bit conversion index can never select garbage.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_digit
         if (gi < MAX_DIGITS) begin : g_used
            assign w_digit[gi] = r_bcd[gi*4 +: 4];
         end else begin : g_unused
            assign w_digit[gi] = 4'd0;
         end
      end
   endgenerate

   assign w_cur_digit    = w_digit[r_idx];
   assign w_acc_next     = (r_acc * 17'd10) + {13'd0, w_cur_digit};
   assign w_limit        = r_mode ? MAX_LIM : PIN_LIM;
   assign w_is_digit     = (key_code <= 4'd9);
   // Codes 14-15 are treated as if no key was pressed at all.
   assign w_key_accepted = key_valid && (key_code <= K_CANCEL);
   assign w_enter_bad    = r_mode ? (r_count == 3'd0) : (r_count != PIN_LIM);

   assign value       = r_value;
   assign value_valid = r_value_valid;
   assign error_valid = r_error_valid;
   assign entry_error = r_entry_error;
   assign digit_count = r_count;
   assign busy        = r_busy;

   // Entry state machine: collect, convert oldest-digit-first, then hold the
   // result or error until acknowledged. Card removal wipes all PIN traces.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= S_IDLE;
         r_busy        <= 1'b0;
         r_mode        <= 1'b0;
         r_bcd         <= '0;
         r_count       <= 3'd0;
         r_idx         <= 3'd0;
         r_acc         <= 17'd0;
         r_timer       <= '0;
         r_value       <= 16'd0;
         r_value_valid <= 1'b0;
         r_error_valid <= 1'b0;
         r_entry_error <= 2'd0;
      end else if (!card_inserted) begin
         r_state       <= S_IDLE;
         r_busy        <= 1'b0;
         r_bcd         <= '0;
         r_count       <= 3'd0;
         r_acc         <= 17'd0;
         r_timer       <= '0;
         r_value       <= 16'd0;
         r_value_valid <= 1'b0;
         r_error_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state       <= S_COLLECT;
                  r_busy        <= 1'b1;
                  r_mode        <= mode;
                  r_bcd         <= '0;
                  r_count       <= 3'd0;
                  r_entry_error <= 2'd0;
                  r_timer       <= '0;
               end
            end

            S_COLLECT: begin
               if (w_key_accepted) begin
                  // Any accepted key restarts the inactivity timer, and it
                  // takes precedence over a timeout on the same edge.
                  r_timer <= '0;
                  if (w_is_digit) begin
                     if (r_count < w_limit) begin
                        r_bcd   <= {r_bcd[BW-5:0], key_code};
                        r_count <= r_count + 3'd1;
                     end
                  end else if (key_code == K_CLEAR) begin
                     r_bcd   <= '0;
                     r_count <= 3'd0;
                  end else if (key_code == K_BACK) begin
                     if (r_count != 3'd0) begin
                        r_bcd   <= {4'd0, r_bcd[BW-1:4]};
                        r_count <= r_count - 3'd1;
                     end
                  end else if (key_code == K_ENTER) begin
                     if (w_enter_bad) begin
                        r_state       <= S_ERR;
                        r_error_valid <= 1'b1;
                        r_entry_error <= 2'd1;
                     end else begin
                        r_state <= S_CONVERT;
                        r_acc   <= 17'd0;
                        r_idx   <= r_count - 3'd1;
                     end
                  end else begin
                     // Cancel: drop the entry silently and leave no digits.
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                     r_bcd   <= '0;
                     r_count <= 3'd0;
                  end
               end else if (r_timer == TIMER_MAX) begin
                  r_state       <= S_ERR;
                  r_error_valid <= 1'b1;
                  r_entry_error <= 2'd3;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end

            S_CONVERT: begin
               r_acc <= w_acc_next;
               if (r_idx == 3'd0) begin
                  if (r_mode && (w_acc_next > AMT_LIM)) begin
                     r_state       <= S_ERR;
                     r_error_valid <= 1'b1;
                     r_entry_error <= 2'd2;
                  end else begin
                     r_state       <= S_HOLD;
                     r_value       <= w_acc_next[15:0];
                     r_value_valid <= 1'b1;
                  end
               end else begin
                  r_idx <= r_idx - 3'd1;
               end
            end

            S_HOLD: begin
               if (value_ack) begin
                  r_state       <= S_IDLE;
                  r_busy        <= 1'b0;
                  r_value_valid <= 1'b0;
               end
            end

            S_ERR: begin
               if (value_ack) begin
                  r_state       <= S_IDLE;
                  r_busy        <= 1'b0;
                  r_error_valid <= 1'b0;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
